// File: rtl/jtframe_rom_pkg.sv
// Shared types and address helpers for the jtframe N-slot SDRAM ROM arbiter.
package jtframe_rom_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // First SDRAM word of the 32-bit line holding a slot address (addr zero-extended).
  function automatic logic [SDRAM_AW-1:0] slot_word(
    input logic [SDRAM_AW-1:0] offset,
    input logic [31:0]         addr,
    input logic                is16
  );
    logic [31:0] w;
    w = is16 ? {addr[31:1], 1'b0} : {1'b0, addr[31:2], 1'b0};
    return offset + w[SDRAM_AW-1:0];
  endfunction

endpackage

// File: rtl/jtframe_rom_nslot_cache.sv
// One-line (32-bit) cache for a single ROM slot: holds data/tag/valid and
// produces hit, ok and the 8/16-bit data view for the current address.
module jtframe_rom_nslot_cache #(
  parameter int AW   = 18,
  parameter bit IS16 = 1'b0
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          load,
  input  logic [AW-1:0] load_tag,
  input  logic [31:0]   load_data,
  output logic [AW-1:0] tag,
  output logic          hit,
  output logic          ok,
  output logic [15:0]   dout
);

  logic [31:0]   data_q, data_d;
  logic [AW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;

  // A 16-bit slot line covers two half-words, an 8-bit slot line four bytes.
  assign tag = IS16 ? (addr >> 1) : (addr >> 2);
  assign hit = valid_q && (tag_q == tag);
  assign ok  = cs && hit && !clr;

  always_comb begin
    if (IS16) dout = addr[0] ? data_q[31:16] : data_q[15:0];
    else      dout = {8'd0, data_q[8*addr[1:0] +: 8]};
  end

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = load_data;
      tag_d   = load_tag;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/jtframe_rom_nslot.sv
// N-slot SDRAM ROM arbiter: per-slot one-line caches, misses arbitrated onto a
// single SDRAM read port in fixed-priority or round-robin order.
module jtframe_rom_nslot
  import jtframe_rom_pkg::*;
#(
  parameter int                        SLOTS   = 9,
  parameter int                        AW      = 18,
  parameter logic [SLOTS-1:0]          DW16    = SLOTS'(9'b1_0000_0010),
  parameter logic [SLOTS*SDRAM_AW-1:0] OFFSETS = {SLOTS{22'd0}},
  parameter bit                        RROBIN  = 1'b0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS*16-1:0]   slot_dout,
  output logic [SLOTS-1:0]      slot_ok,
  output logic                  sdram_req,
  output logic [SDRAM_AW-1:0]   sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_dst,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam bit RR = RROBIN && (SLOTS > 1);

  logic [SLOTS-1:0]               hit, miss;
  logic [SLOTS-1:0][AW-1:0]       tag_all;
  logic [SLOTS-1:0][SDRAM_AW-1:0] word_all;
  logic [SLOTS-1:0][15:0]         dout_all;

  state_e               state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d, rr_q, rr_d, pick;
  logic                 found, load;
  logic                 req_q, req_d;
  logic [SDRAM_AW-1:0]  saddr_q, saddr_d;
  logic [AW-1:0]        rtag_q, rtag_d;

  // The burst strobe carries no information we need; capture is on data_rdy.
  logic unused_dst;
  assign unused_dst = data_dst;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign word_all[i] = slot_word(OFFSETS[SDRAM_AW*i +: SDRAM_AW],
                                   32'(slot_addr[AW*i +: AW]), DW16[i]);
    jtframe_rom_nslot_cache #(.AW(AW), .IS16(DW16[i])) u_cache (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (downloading),
      .cs        (slot_cs[i]),
      .addr      (slot_addr[AW*i +: AW]),
      .load      (load && (grant_q == IW'(i))),
      .load_tag  (rtag_q),
      .load_data (data_read),
      .tag       (tag_all[i]),
      .hit       (hit[i]),
      .ok        (slot_ok[i]),
      .dout      (dout_all[i])
    );
  end

  assign slot_dout  = dout_all;
  assign miss       = slot_cs & ~hit;
  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;
  // Ack and data may coincide in REQ; the data is captured in that same cycle.
  assign load = !downloading && data_rdy &&
                ((state_q == WAIT) || (state_q == REQ && sdram_ack));

  // Round-robin scans cyclically from the slot after the last one served.
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < SLOTS; k++) begin
      idx = RR ? (int'(rr_q) + 1 + k) % SLOTS : k;
      if (!found && miss[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (downloading) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (found)     state_d = REQ;
        REQ:     if (sdram_ack) state_d = data_rdy ? IDLE : WAIT;
        WAIT:    if (data_rdy)  state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    grant_d = grant_q;
    rr_d    = rr_q;
    req_d   = req_q;
    saddr_d = saddr_q;
    rtag_d  = rtag_q;
    if (downloading) begin
      req_d = 1'b0;
    end else begin
      if (state_q == IDLE && found) begin
        grant_d = pick;
        saddr_d = word_all[pick];
        rtag_d  = tag_all[pick];
        req_d   = 1'b1;
      end
      if (state_q == REQ && sdram_ack) req_d = 1'b0;
      if (load) rr_d = grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      rr_q    <= IW'(SLOTS - 1);
      req_q   <= 1'b0;
      saddr_q <= '0;
      rtag_q  <= '0;
    end else begin
      grant_q <= grant_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
      rtag_q  <= rtag_d;
    end
  end

endmodule
